fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: fetches {program, PC} from instruction memory one word
// at a time, issues it downstream with a valid/ready handshake and steps the PC.
module fetch_sequencer #(
    parameter int PC_W   = 16,
    parameter int INST_W = 10,
    parameter int NPROG  = 2,
    localparam int PROG_W = $clog2(NPROG)
) (
    input  logic                   CLK,
    input  logic                   Init,
    input  logic [PROG_W-1:0]      Program,
    input  logic                   Start,
    input  logic                   Halt,
    input  logic                   BranchTaken,
    input  logic [PC_W-1:0]        BranchTarget,
    input  logic                   SkipNext,
    output logic                   ImemReq,
    output logic [PROG_W+PC_W-1:0] ImemAddr,
    input  logic                   ImemAck,
    input  logic [INST_W-1:0]      ImemData,
    output logic [INST_W-1:0]      Instruction,
    output logic                   InstValid,
    input  logic                   InstReady,
    output logic [PC_W-1:0]        PC,
    output logic                   Running,
    output logic                   Done
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALTED} state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [PROG_W-1:0]   prog_q, prog_d;
    logic                halt_pend_q, halt_pend_d;
    logic [PC_W-1:0]     pc_next;

    // Width-limited adds give the modulo-2^PC_W wrap for free.
    always_comb begin
        pc_next = pc_q + PC_W'(1);
        if (BranchTaken)
            pc_next = BranchTarget;
        else if (SkipNext)
            pc_next = pc_q + PC_W'(2);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        prog_d      = prog_q;
        halt_pend_d = halt_pend_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (Start) begin
                    prog_d      = Program;
                    pc_d        = '0;
                    halt_pend_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (ImemAck) begin
                    halt_pend_d = 1'b0;
                    // A halt seen during the fetch drops the returning word unissued.
                    if (halt_pend_q || Halt) begin
                        state_d = S_HALTED;
                    end else begin
                        inst_d  = ImemData;
                        state_d = S_ISSUE;
                    end
                end else if (Halt) begin
                    halt_pend_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (InstReady) begin
                    pc_d        = pc_next;
                    halt_pend_d = 1'b0;
                    state_d     = (Halt || halt_pend_q) ? S_HALTED : S_FETCH;
                end else if (Halt) begin
                    halt_pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Init) begin
        if (!Init) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            inst_q      <= '0;
            prog_q      <= '0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            prog_q      <= prog_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    assign ImemReq     = (state_q == S_FETCH);
    assign ImemAddr    = {prog_q, pc_q};
    assign InstValid   = (state_q == S_ISSUE);
    assign Instruction = inst_q;
    assign PC          = pc_q;
    assign Running     = (state_q == S_FETCH) || (state_q == S_ISSUE);
    assign Done        = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: variable-latency memory responder, a phase/PC model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_sequencer;

    localparam int PC_W   = 16;
    localparam int INST_W = 10;

    logic              CLK = 1'b0;
    logic              Init = 1'b0;
    logic [0:0]        Program = '0;
    logic              Start = 1'b0, Halt = 1'b0, BranchTaken = 1'b0, SkipNext = 1'b0;
    logic [PC_W-1:0]   BranchTarget = '0;
    logic              InstReady = 1'b1;
    logic              ImemReq, InstValid, Running, Done;
    logic [PC_W:0]     ImemAddr;
    logic [INST_W-1:0] Instruction;
    logic [PC_W-1:0]   PC;
    logic              ImemAck;
    logic [INST_W-1:0] mem_data = '0;
    logic              mem_ack = 1'b0, stray_ack = 1'b0, mem_en = 1'b1;
    int                lat = 1;

    // narrow-PC instance runs in lockstep for the wrap checks
    logic              req4, valid4, run4, done4;
    logic [4:0]        addr4;
    logic [INST_W-1:0] inst4;
    logic [3:0]        pc4;

    assign ImemAck = mem_ack | stray_ack;

    fetch_sequencer #(.PC_W(PC_W), .INST_W(INST_W), .NPROG(2)) dut (
        .CLK(CLK), .Init(Init), .Program(Program), .Start(Start), .Halt(Halt),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .SkipNext(SkipNext),
        .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck), .ImemData(mem_data),
        .Instruction(Instruction), .InstValid(InstValid), .InstReady(InstReady),
        .PC(PC), .Running(Running), .Done(Done));

    fetch_sequencer #(.PC_W(4), .INST_W(INST_W), .NPROG(2)) dut4 (
        .CLK(CLK), .Init(Init), .Program(Program), .Start(Start), .Halt(Halt),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget[3:0]), .SkipNext(SkipNext),
        .ImemReq(req4), .ImemAddr(addr4), .ImemAck(ImemAck), .ImemData(mem_data),
        .Instruction(inst4), .InstValid(valid4), .InstReady(InstReady),
        .PC(pc4), .Running(run4), .Done(done4));

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [INST_W-1:0] dataf(input logic [PC_W:0] a);
        logic [PC_W:0] t;
        t = (a * 17'd37) ^ 17'h155;
        return t[INST_W-1:0];
    endfunction

    // memory: ack arrives `lat` cycles after the request is first seen
    int cnt = 0;
    always @(posedge CLK) begin
        #1;
        if (!Init || !mem_en || mem_ack || !ImemReq) begin
            mem_ack = 1'b0;
            cnt = 0;
        end else if (cnt >= lat) begin
            mem_ack  = 1'b1;
            mem_data = dataf(ImemAddr);
        end else begin
            cnt++;
        end
    end

    // model: 0 idle, 1 fetching, 2 issuing, 3 halted
    int            ph = 0;
    logic [15:0]   m_pc = '0;
    logic          m_prog = 1'b0, m_pend = 1'b0;
    logic [INST_W-1:0] m_inst = '0;
    bit            log_en = 1'b0;
    logic [PC_W:0] addr_q[$];
    int            acc_q[$];
    int            last_ack_cyc = 0;

    always @(negedge CLK) begin
        if (!Init) begin
            ph = 0; m_pc = '0; m_prog = 1'b0; m_pend = 1'b0; m_inst = '0;
            chk("rst_outputs", {ImemReq, InstValid, Running, Done, PC}, 64'd0);
        end else begin
            chk("m_req",   ImemReq,   ph == 1);
            chk("m_valid", InstValid, ph == 2);
            chk("m_run",   Running,   ph == 1 || ph == 2);
            chk("m_done",  Done,      ph == 3);
            chk("m_pc",    PC,        m_pc);
            if (ph == 1) chk("m_addr", ImemAddr, {m_prog, m_pc});
            if (ph == 2) chk("m_inst", Instruction, m_inst);
            if (ImemReq && ImemAck) begin
                last_ack_cyc = cyc;
                if (log_en) addr_q.push_back(ImemAddr);
            end
            if (InstValid && InstReady && log_en) acc_q.push_back(cyc);
            case (ph)
                0, 3: if (Start) begin
                    m_prog = Program[0]; m_pc = '0; m_pend = 1'b0; ph = 1;
                end
                1: if (ImemAck) begin
                    if (m_pend || Halt) ph = 3;
                    else begin m_inst = dataf({m_prog, m_pc}); ph = 2; end
                    m_pend = 1'b0;
                end else if (Halt) m_pend = 1'b1;
                2: if (InstReady) begin
                    if (BranchTaken)   m_pc = BranchTarget;
                    else if (SkipNext) m_pc = 16'((int'(m_pc) + 2) % 65536);
                    else               m_pc = 16'((int'(m_pc) + 1) % 65536);
                    ph = (Halt || m_pend) ? 3 : 1;
                    m_pend = 1'b0;
                end else if (Halt) m_pend = 1'b1;
                default: ph = 0;
            endcase
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid_pc(input logic [15:0] p);
        bit ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (InstValid && PC == p) ok = 1'b1;
            else tick();
        end
        chk("timeout_valid_pc", ok, 1'b1);
    endtask

    task automatic wait_req();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (ImemReq) ok = 1'b1;
            else tick();
        end
        chk("timeout_req", ok, 1'b1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (Done) ok = 1'b1;
            else tick();
        end
        chk("timeout_done", ok, 1'b1);
    endtask

    logic [INST_W-1:0] held;
    int                done_cyc;

    initial begin
        // reset state
        tick(2);
        chk("rst_req", ImemReq, 1'b0);
        chk("rst_inst", Instruction, '0);
        chk("rst_done", Done, 1'b0);
        Init = 1'b1;
        tick();

        // program 1, ack latency 1, continuous ready; Start/Program changes mid-run ignored
        Program = 1'b1; Start = 1'b1; log_en = 1'b1;
        tick();
        Start = 1'b0; Program = 1'b0;
        tick(2);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_valid_pc(16'd2);
        tick();
        log_en = 1'b0;
        chk("seq_len", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            chk("seq_a0", addr_q[0], 17'h10000);
            chk("seq_a1", addr_q[1], 17'h10001);
            chk("seq_a2", addr_q[2], 17'h10002);
        end
        chk("acc_len", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("rate_0", acc_q[1] - acc_q[0], 3);
            chk("rate_1", acc_q[2] - acc_q[1], 3);
        end
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        wait_done();

        // branch / skip / priority, restart from halted with program 0
        Program = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_valid_pc(16'd5);
        BranchTaken = 1'b1; BranchTarget = 16'h0040;
        tick();
        BranchTaken = 1'b0;
        wait_req();
        chk("branch_addr", ImemAddr, 17'h00040);
        wait_valid_pc(16'h0041);
        BranchTaken = 1'b1; BranchTarget = 16'd7;
        tick();
        BranchTaken = 1'b0;
        wait_valid_pc(16'd7);
        SkipNext = 1'b1;
        tick();
        SkipNext = 1'b0;
        wait_req();
        chk("skip_pc", PC, 16'd9);
        wait_valid_pc(16'd9);
        BranchTaken = 1'b1; SkipNext = 1'b1; BranchTarget = 16'd15;
        tick();
        BranchTaken = 1'b0; SkipNext = 1'b0;
        wait_req();
        chk("prio_pc", PC, 16'd15);

        // 4-bit PC wrap on the narrow instance
        wait_valid_pc(16'd15);
        chk("w4_at15", pc4, 4'd15);
        tick();
        wait_req();
        chk("w4_inc_wrap", pc4, 4'd0);
        wait_valid_pc(16'd16);
        BranchTaken = 1'b1; BranchTarget = 16'd14;
        tick();
        BranchTaken = 1'b0;
        wait_valid_pc(16'd14);
        SkipNext = 1'b1;
        tick();
        SkipNext = 1'b0;
        wait_req();
        chk("w4_skip14", pc4, 4'd0);
        wait_valid_pc(16'd16);
        BranchTaken = 1'b1; BranchTarget = 16'd15;
        tick();
        BranchTaken = 1'b0;
        wait_valid_pc(16'd15);
        SkipNext = 1'b1;
        tick();
        SkipNext = 1'b0;
        wait_req();
        chk("w4_skip15", pc4, 4'd1);

        // stall in issue with a halt recorded while not ready
        InstReady = 1'b0;
        wait_valid_pc(16'd17);
        held = Instruction;
        for (int i = 0; i < 5; i++) begin
            Halt = (i == 1);
            tick();
            chk("stall_inst", Instruction, held);
            chk("stall_pc", PC, 16'd17);
            chk("stall_req", ImemReq, 1'b0);
        end
        Halt = 1'b0; InstReady = 1'b1;
        tick();
        chk("halt_pend_issue", Done, 1'b1);

        // halt during a long fetch: word dropped, Done the cycle after ack
        lat = 4; Program = 1'b0; Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_req();
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        done_cyc = -1;
        for (int i = 0; i < 20 && done_cyc < 0; i++) begin
            if (Done) done_cyc = cyc;
            else begin
                chk("halt_no_valid", InstValid, 1'b0);
                tick();
            end
        end
        chk("done_after_ack", done_cyc - last_ack_cyc, 1);
        tick(3);
        chk("halt_pc_frozen", PC, 16'd0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("restart_addr", {ImemReq, ImemAddr}, {1'b1, 17'h00000});

        // reset mid-fetch, then a stray ack
        tick();
        Init = 1'b0; mem_en = 1'b0;
        #1;
        chk("async_rst", {ImemReq, InstValid, Running, Done, PC, Instruction}, 64'd0);
        tick();
        Init = 1'b1;
        tick();
        stray_ack = 1'b1; mem_data = 10'h3ff;
        tick();
        stray_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stray_ack_ignored", {InstValid, Running}, 2'b00);
            tick();
        end
        mem_en = 1'b1; lat = 1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
